// File: rtl/aq_djpeg_feeder.sv
// Byte-to-word feeder for the JPEG decoder input port: packs host bytes big-endian
// into 32-bit words and buffers them in a first-word-fall-through FIFO.
module aq_djpeg_feeder #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Clear,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteInEnable,
  input  logic                  ByteInLast,
  output logic                  ByteInReady,
  output logic [31:0]           DataOut,
  output logic                  DataOutEnable,
  input  logic                  DataOutRead,
  output logic                  LastWordOut,
  output logic [DEPTH_LOG2:0]   Level
);

  localparam int                 DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [1:0]            lane_q, lane_d;
  logic [23:0]           pack_q, pack_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [31:0]           mem_q [DEPTH];
  logic                  tag_q [DEPTH];

  logic        acc, push, pop;
  logic [31:0] word;

  assign ByteInReady   = (level_q < FULL);
  assign DataOutEnable = (level_q != '0);
  assign DataOut       = DataOutEnable ? mem_q[rd_ptr_q] : 32'h0;
  assign LastWordOut   = tag_q[rd_ptr_q] & DataOutEnable;
  assign Level         = level_q;

  always_comb begin
    acc  = ByteInEnable & ByteInReady & ~Clear;
    pop  = DataOutRead & DataOutEnable & ~Clear;
    push = acc & ((lane_q == 2'd3) | ByteInLast);

    // Earlier lanes come from the packing register, later lanes are padded.
    word = {4{PAD_BYTE}};
    case (lane_q)
      2'd0: word = {ByteIn, PAD_BYTE, PAD_BYTE, PAD_BYTE};
      2'd1: word = {pack_q[23:16], ByteIn, PAD_BYTE, PAD_BYTE};
      2'd2: word = {pack_q[23:8], ByteIn, PAD_BYTE};
      2'd3: word = {pack_q[23:0], ByteIn};
      default: word = {4{PAD_BYTE}};
    endcase

    lane_d   = lane_q;
    pack_d   = pack_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (Clear) begin
      lane_d   = 2'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (acc) begin
        lane_d = push ? 2'd0 : lane_q + 2'd1;
        case (lane_q)
          2'd0: pack_d[23:16] = ByteIn;
          2'd1: pack_d[15:8]  = ByteIn;
          2'd2: pack_d[7:0]   = ByteIn;
          default: pack_d = pack_q;
        endcase
      end
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q   <= 2'd0;
      pack_q   <= 24'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: Level gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
      tag_q[wr_ptr_q] <= ByteInLast;
    end
  end

endmodule
